i_scan_controller: RTL
======================

# i_scan_controller

Raster-scan controller for image indexing. Walks a frame of `img_width` x `img_height` pixels in row-major order, tracking column and row counts with 13-bit wrap logic. Issues one pixel-fetch request per handshake to the frame-buffer read port. Sits between the frame-level start/done control and the pixel memory interface, and sequences the column/row indexing that the downstream filter datapath consumes.

## Interface
Parameters:
- `ADDR_W`, 32, width of pixel address
- `DIM_W`, 13, width of image dimensions and indices

Ports:
- `clk`  in  1  system clock; all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin frame scan; sampled only in IDLE
- `abort`  in  1  synchronous scan cancel; effective in LOAD and SCAN
- `img_width`  in  DIM_W  pixels per row; latched on start
- `img_height`  in  DIM_W  rows per frame; latched on start
- `base_addr`  in  ADDR_W  address of pixel (0,0); latched on start
- `req_valid`  out  1  pixel request valid
- `req_ready`  in  1  memory accepts request
- `req_addr`  out  ADDR_W  pixel address
- `req_col`  out  DIM_W  column index of current request
- `req_row`  out  DIM_W  row index of current request
- `req_last`  out  1  current request is the final pixel of the frame
- `busy`  out  1  high in LOAD, SCAN, DONE
- `done`  out  1  one-cycle pulse on normal frame completion
- `err`  out  1  one-cycle pulse, same cycle as `done`, on a rejected frame

## Operation
- States: IDLE, LOAD, SCAN, DONE.
- IDLE: on `start`=1, latch width, height, base (and stride when enabled), then go to LOAD. No `start` means stay in IDLE.
- LOAD: clear `col`/`row` to 0. Set `addr` = `line_start` = base.
  - If width==0 or height==0 (or stride<width when enabled): go to DONE with error flag set.
  - Otherwise go to SCAN.
- SCAN: `req_valid`=1. A handshake is `req_valid && req_ready`. On each handshake:
  - If col != width-1: col+1, addr+1.
  - Else if row != height-1: col=0, row+1, `line_start` += stride, `addr` = new `line_start`.
  - Else (last pixel): go to DONE.
- DONE: `done`=1, or `err`=1 if the error flag is set (never both). Then go to IDLE.
- `abort` in LOAD or SCAN: go to IDLE next cycle. No `done`/`err` pulse. In-flight `req_valid` drops without a handshake.
- `start` outside IDLE is ignored. `abort` in IDLE or DONE is ignored. `abort` and a handshake in the same cycle: the abort wins, though the handshake still counts at the memory side.
- Stride is `img_width` unless the stride feature is compiled in.
- Arithmetic:
  - Address adds are modulo 2^ADDR_W.
  - Dimensions are unsigned. 8191 x 8191 is legal.
  - `col`/`row` never exceed dim-1, so no 13-bit overflow.
- `req_last` = SCAN && col==width-1 && row==height-1.

## Timing
- Reset values:
  - state IDLE.
  - `req_valid`, `busy`, `done`, `err`, `req_last` = 0.
  - `req_addr`, `req_col`, `req_row` = 0.
- `start` sampled at edge k puts the block in LOAD after k. `req_valid` goes high after edge k+1, with addr=base, col=0, row=0.
- While `req_valid`=1 and `req_ready`=0, `req_addr`/`req_col`/`req_row`/`req_last` hold stable.
- With `req_ready` tied high: one request per cycle, and a W x H frame takes exactly W*H SCAN cycles.
- `done` is asserted the cycle after the last handshake. `busy` falls one cycle after `done`.
- Earliest back-to-back start: the cycle after `done`, i.e. the first IDLE cycle.
- `rst` mid-operation clears all state and outputs immediately, independent of `clk`.

## Configuration
- `I_SCAN_STRIDE_EN` defined:
  - Adds input `row_stride` (DIM_W bits, latched on start), used as the row-to-row address increment for padded frame buffers.
  - `row_stride` < `img_width` is rejected via `err`.
- `I_SCAN_STRIDE_EN` undefined:
  - No `row_stride` port.
  - Stride equals latched `img_width`; addresses are contiguous base..base+W*H-1.

## Test plan
- width=3, height=2, base=0x100, `req_ready`=1 -> addresses 0x100..0x105 on 6 consecutive cycles. (col,row) sequence is (0,0)(1,0)(2,0)(0,1)(1,1)(2,1). `req_last` only on the 6th. `done` pulses 1 cycle later.
- width=10, height=1, `req_ready` toggles 0/1 every cycle -> outputs stable during stalls. Exactly 10 handshakes, col 0..9. `done` follows the 10th.
- width=0, height=5 -> no `req_valid`. `err` pulses in cycle 3 after start, and `done` stays 0.
- width=100, height=4, assert `abort` after 150 handshakes -> `req_valid` low the next cycle, back in IDLE, no `done`. A new `start` rescans from base.
- `rst` asserted mid-SCAN between clock edges -> all outputs 0 immediately. Subsequent 8191x1 frame completes with col reaching 8190 and no wrap error.
- With `I_SCAN_STRIDE_EN`: width=4, stride=6, height=3, base=0 -> addresses 0-3, 6-9, 12-15. Stride=3 with width=4 -> `err`.

Source files
------------

// File: rtl/i_scan_controller.sv
// i_scan_controller: raster-scan walker that issues one pixel-fetch request
// per handshake over an img_width x img_height frame in row-major order.
// Optional feature macro: I_SCAN_STRIDE_EN adds a latched row_stride input
// for padded frame buffers; otherwise the row increment is img_width.
module i_scan_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef I_SCAN_STRIDE_EN
  input  logic [DIM_W-1:0]  row_stride,
`endif
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DIM_W-1:0]  req_col,
  output logic [DIM_W-1:0]  req_row,
  output logic              req_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_n;

  // Latched frame parameters and walk registers.
  logic [DIM_W-1:0]  width_q, width_n;
  logic [DIM_W-1:0]  height_q, height_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [DIM_W-1:0]  stride_q, stride_n;
  logic [ADDR_W-1:0] line_start, line_n;
  logic              err_flag, err_flag_n;
  logic [DIM_W-1:0]  col_n, row_n;
  logic [ADDR_W-1:0] addr_n;
  logic              valid_n, busy_n, done_n, err_n, last_n;
  logic              bad_frame;
  logic              at_row_end, at_col_end;

  // Frame rejection check done in LOAD.
  always_comb begin
`ifdef I_SCAN_STRIDE_EN
    bad_frame = (width_q == '0) || (height_q == '0) || (stride_q < width_q);
`else
    bad_frame = (width_q == '0) || (height_q == '0);
`endif
  end

  assign at_col_end = (req_col == width_q - DIM_W'(1));
  assign at_row_end = (req_row == height_q - DIM_W'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state, datapath next values and next registered outputs.
  always_comb begin
    state_n    = state;
    width_n    = width_q;
    height_n   = height_q;
    base_n     = base_q;
    stride_n   = stride_q;
    line_n     = line_start;
    err_flag_n = err_flag;
    col_n      = req_col;
    row_n      = req_row;
    addr_n     = req_addr;

    case (state)
      S_IDLE: begin
        if (start) begin
          width_n  = img_width;
          height_n = img_height;
          base_n   = base_addr;
`ifdef I_SCAN_STRIDE_EN
          stride_n = row_stride;
`else
          stride_n = img_width;
`endif
          state_n  = S_LOAD;
        end
      end
      S_LOAD: begin
        col_n  = '0;
        row_n  = '0;
        addr_n = base_q;
        line_n = base_q;
        if (abort) begin
          state_n = S_IDLE;
        end else if (bad_frame) begin
          err_flag_n = 1'b1;
          state_n    = S_DONE;
        end else begin
          err_flag_n = 1'b0;
          state_n    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (req_ready) begin
          if (!at_col_end) begin
            col_n  = req_col + DIM_W'(1);
            addr_n = req_addr + ADDR_W'(1);
          end else if (!at_row_end) begin
            col_n  = '0;
            row_n  = req_row + DIM_W'(1);
            line_n = line_start + ADDR_W'(stride_q);
            addr_n = line_n;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    valid_n = (state_n == S_SCAN);
    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_DONE) && !err_flag_n;
    err_n   = (state_n == S_DONE) && err_flag_n;
    last_n  = (state_n == S_SCAN) &&
              (col_n == width_q - DIM_W'(1)) &&
              (row_n == height_q - DIM_W'(1));
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q    <= '0;
      height_q   <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      line_start <= '0;
      err_flag   <= 1'b0;
      req_col    <= '0;
      req_row    <= '0;
      req_addr   <= '0;
      req_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      req_last   <= 1'b0;
    end else begin
      width_q    <= width_n;
      height_q   <= height_n;
      base_q     <= base_n;
      stride_q   <= stride_n;
      line_start <= line_n;
      err_flag   <= err_flag_n;
      req_col    <= col_n;
      req_row    <= row_n;
      req_addr   <= addr_n;
      req_valid  <= valid_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
      req_last   <= last_n;
    end
  end

endmodule
